flag_ctrl: RTL and testbench

Flag-register controller for the pipelined WISC CPU. Sits between decode, the EX-stage ALU and the 3-bit `Flag` register. Tracks the flag-writing instruction in EX and drives the register's write enable with a per-opcode merged value, so partial (Z-only) updates preserve untouched bits. Resolves branch conditions for the instruction in ID, forwarding in-flight flags or stalling one cycle, and freezes flag state after HLT.

---
 rtl/wisc_pkg.sv | 53 +++++
 rtl/flag_cond.sv | 35 +++
 rtl/flag_ctrl.sv | 91 +++++++++
 tb/tb_flag_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, branch conditions, flag bit positions, write masks.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LHB    = 4'b1010,
    OP_LLB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    CCC_NE = 3'b000,
    CCC_EQ = 3'b001,
    CCC_GT = 3'b010,
    CCC_LT = 3'b011,
    CCC_GE = 3'b100,
    CCC_LE = 3'b101,
    CCC_OV = 3'b110,
    CCC_UN = 3'b111
  } ccc_e;

  // Flag vector is {N,V,Z}
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Which flag bits an opcode is allowed to write; shifts and XOR only touch Z.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b001;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_cond.sv
// Branch condition evaluator: decides taken/not-taken from a ccc field and {N,V,Z}.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: ccc (condition code), flags ({N,V,Z}) -> taken.
module flag_cond
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n;
  logic v;
  logic z;

  always_comb begin
    n     = flags[FLAG_N];
    v     = flags[FLAG_V];
    z     = flags[FLAG_Z];
    taken = 1'b0;
    case (ccc)
      CCC_NE: taken = ~z;
      CCC_EQ: taken = z;
      CCC_GT: taken = ~z & ~n;
      CCC_LT: taken = n;
      CCC_GE: taken = z | ~n;
      CCC_LE: taken = n | z;
      CCC_OV: taken = v;
      CCC_UN: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// Flag register controller: tracks the flag writer in EX, merges partial flag writes, resolves ID branches, freezes after HLT.
// Latency: flag setter in ID at t drives flag_we at t+1; branch resolves same cycle (FWD=1) or after one stall cycle (FWD=0).
// Backpressure: stall_in/flush insert an EX bubble; flag_stall holds ID when FWD=0 and a branch waits on an in-flight write.
// Ports: clk, rst (async, active-high); ID: id_valid, id_opcode, id_ccc, stall_in, flush;
//        EX/Flag: ex_alu_flags, flag_q -> flag_we, flag_new; branch: flag_stall, br_valid, br_taken; halted.
module flag_ctrl
  import wisc_pkg::*;
#(
  parameter int FWD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [2:0] id_ccc,
  input  logic       stall_in,
  input  logic       flush,
  input  logic [2:0] ex_alu_flags,
  input  logic [2:0] flag_q,
  output logic       flag_we,
  output logic [2:0] flag_new,
  output logic       flag_stall,
  output logic       br_valid,
  output logic       br_taken,
  output logic       halted
);

  localparam logic FWD_EN = (FWD != 0);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       ex_valid_q, ex_valid_d;
  logic [2:0] ex_mask_q, ex_mask_d;

  logic       id_br;
  logic       advance;
  logic [2:0] eff_flags;
  logic       cond_taken;

  flag_cond u_cond (
    .ccc   (id_ccc),
    .flags (eff_flags),
    .taken (cond_taken)
  );

  always_comb begin
    halted     = (state_q == ST_HALTED);

    // Unmasked bits come from the live register so Z-only writers keep N and V.
    flag_we    = ex_valid_q & (|ex_mask_q);
    flag_new   = (ex_alu_flags & ex_mask_q) | (flag_q & ~ex_mask_q);

    // Bypass the in-flight write so a branch right behind a setter needs no stall.
    eff_flags  = (FWD_EN && flag_we) ? flag_new : flag_q;

    id_br      = id_valid & ((id_opcode == OP_B) | (id_opcode == OP_BR)) & ~halted;
    flag_stall = id_br & flag_we & ~FWD_EN;
    br_valid   = id_br & ~flag_stall & ~stall_in & ~flush;
    // Held low when nothing resolves so downstream never sees a stale taken.
    br_taken   = br_valid & cond_taken;

    // Instruction leaves ID into EX; any hold or squash sends a bubble instead.
    advance    = id_valid & ~stall_in & ~flag_stall & ~flush & ~halted;
    ex_valid_d = advance;
    ex_mask_d  = flag_mask(id_opcode);

    state_d    = state_q;
    case (state_q)
      ST_RUN:    if (advance && (id_opcode == OP_HLT)) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ex_valid_q <= 1'b0;
      ex_mask_q  <= 3'b000;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_mask_q  <= ex_mask_d;
    end
  end

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl: one instance with bypass, one with stall, driven in lockstep.
// Latency: checks sampled 2 time units after each falling edge, inputs driven on the falling edge.
// Backpressure: exercised through stall_in, flush and the FWD=0 flag stall.
module tb_flag_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [2:0] id_ccc;
  logic       stall_in;
  logic       flush;
  logic [2:0] ex_alu_flags;
  logic [2:0] flag_q;

  logic       we1, st1, bv1, bt1, h1;
  logic [2:0] new1;
  logic       we0, st0, bv0, bt0, h0;
  logic [2:0] new0;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  flag_ctrl #(.FWD(1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_ccc(id_ccc),
    .stall_in(stall_in), .flush(flush), .ex_alu_flags(ex_alu_flags), .flag_q(flag_q),
    .flag_we(we1), .flag_new(new1), .flag_stall(st1), .br_valid(bv1), .br_taken(bt1),
    .halted(h1)
  );

  flag_ctrl #(.FWD(0)) u_stl (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_ccc(id_ccc),
    .stall_in(stall_in), .flush(flush), .ex_alu_flags(ex_alu_flags), .flag_q(flag_q),
    .flag_we(we0), .flag_new(new0), .flag_stall(st0), .br_valid(bv0), .br_taken(bt0),
    .halted(h0)
  );

  task automatic push(input string tag, input logic [3:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [3:0] obs);
    sb_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%0h required=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Expected control outputs of one instance, in a fixed order.
  task automatic exp_dut(input string t, input logic we, input logic st, input logic bv,
                         input logic bt, input logic h);
    push({t, ".flag_we"}, {3'b0, we});
    push({t, ".flag_stall"}, {3'b0, st});
    push({t, ".br_valid"}, {3'b0, bv});
    push({t, ".br_taken"}, {3'b0, bt});
    push({t, ".halted"}, {3'b0, h});
  endtask

  task automatic exp_both(input string t, input logic we, input logic st, input logic bv,
                          input logic bt, input logic h);
    exp_dut({t, "/fwd1"}, we, st, bv, bt, h);
    exp_dut({t, "/fwd0"}, we, st, bv, bt, h);
  endtask

  task automatic chk_all();
    chk({3'b0, we1}); chk({3'b0, st1}); chk({3'b0, bv1}); chk({3'b0, bt1}); chk({3'b0, h1});
    chk({3'b0, we0}); chk({3'b0, st0}); chk({3'b0, bv0}); chk({3'b0, bt0}); chk({3'b0, h0});
  endtask

  task automatic exp_new(input string t, input logic [2:0] v);
    push({t, "/fwd1.flag_new"}, {1'b0, v});
    push({t, "/fwd0.flag_new"}, {1'b0, v});
  endtask

  task automatic chk_new();
    chk({1'b0, new1});
    chk({1'b0, new0});
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] c,
                       input logic s, input logic f);
    id_valid  = v;
    id_opcode = op;
    id_ccc    = c;
    stall_in  = s;
    flush     = f;
  endtask

  // Branch conditions written straight from the {N,V,Z} truth table.
  function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    logic [2:0] fl [5];
    fl[0] = 3'b000; fl[1] = 3'b001; fl[2] = 3'b100; fl[3] = 3'b010; fl[4] = 3'b101;

    rst = 1'b1;
    drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    ex_alu_flags = 3'b000;
    flag_q       = 3'b000;
    #2;
    exp_both("reset", 0, 0, 0, 0, 0);
    chk_all();

    @(negedge clk); rst = 1'b0;

    // ADD writes all three flags one cycle after ID
    @(negedge clk); drive(1'b1, 4'h0, 3'd0, 1'b0, 1'b0);
    #2; exp_both("add_id", 0, 0, 0, 0, 0); chk_all();
    @(negedge clk); drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    ex_alu_flags = 3'b110; flag_q = 3'b000;
    #2; exp_both("add_ex", 1, 0, 0, 0, 0); exp_new("add_ex", 3'b110); chk_all(); chk_new();

    // Asynchronous reset while an ADD sits in EX
    @(negedge clk); drive(1'b1, 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    #2; exp_both("pre_rst", 1, 0, 0, 0, 0); chk_all();
    #1; rst = 1'b1;
    #1; exp_both("mid_rst", 0, 0, 0, 0, 0); chk_all();
    @(negedge clk); rst = 1'b0;

    // XOR only touches Z, N and V preserved
    drive(1'b1, 4'h2, 3'd0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    ex_alu_flags = 3'b001; flag_q = 3'b110;
    #2; exp_both("xor_ex", 1, 0, 0, 0, 0); exp_new("xor_ex", 3'b111); chk_all(); chk_new();

    // Back-to-back ADD then XOR, each merging with its own cycle's flag_q
    @(negedge clk); drive(1'b1, 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 4'h2, 3'd0, 1'b0, 1'b0);
    ex_alu_flags = 3'b101; flag_q = 3'b000;
    #2; exp_both("b2b_add", 1, 0, 0, 0, 0); exp_new("b2b_add", 3'b101); chk_all(); chk_new();
    @(negedge clk); drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    ex_alu_flags = 3'b000; flag_q = 3'b101;
    #2; exp_both("b2b_xor", 1, 0, 0, 0, 0); exp_new("b2b_xor", 3'b100); chk_all(); chk_new();

    // SUB then B EQ: bypass resolves at once, stall variant waits a cycle
    @(negedge clk); drive(1'b1, 4'h1, 3'd0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 4'hC, 3'd1, 1'b0, 1'b0);
    ex_alu_flags = 3'b001; flag_q = 3'b000;
    #2;
    exp_dut("sub_b/fwd1", 1, 0, 1, 1, 0);
    exp_dut("sub_b/fwd0", 1, 1, 0, 0, 0);
    exp_new("sub_b", 3'b001);
    chk_all(); chk_new();
    @(negedge clk); ex_alu_flags = 3'b000; flag_q = 3'b001;
    #2; exp_both("sub_b_next", 0, 0, 1, 1, 0); chk_all();

    // LW does not write flags, so a BR behind it resolves from flag_q
    @(negedge clk); drive(1'b1, 4'h8, 3'd0, 1'b0, 1'b0); flag_q = 3'b000;
    #2; exp_both("lw_id", 0, 0, 0, 0, 0); chk_all();
    @(negedge clk); drive(1'b1, 4'hD, 3'd2, 1'b0, 1'b0);
    #2; exp_both("br_gt_t", 0, 0, 1, 1, 0); chk_all();
    @(negedge clk); flag_q = 3'b001;
    #2; exp_both("br_gt_nt", 0, 0, 1, 0, 0); chk_all();

    // Flush squashes a SUB; flush/stall_in suppress branch resolution
    @(negedge clk); drive(1'b1, 4'h1, 3'd0, 1'b0, 1'b1); flag_q = 3'b000;
    @(negedge clk); drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0); ex_alu_flags = 3'b111;
    #2; exp_both("flush_sub", 0, 0, 0, 0, 0); chk_all();
    @(negedge clk); drive(1'b1, 4'hC, 3'd7, 1'b0, 1'b1);
    #2; exp_both("flush_br", 0, 0, 0, 0, 0); chk_all();
    @(negedge clk); drive(1'b1, 4'hC, 3'd7, 1'b1, 1'b0);
    #2; exp_both("stall_br", 0, 0, 0, 0, 0); chk_all();
    @(negedge clk); drive(1'b1, 4'h0, 3'd0, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    #2; exp_both("stall_flush", 0, 0, 0, 0, 0); chk_all();

    // Every condition code against several flag patterns, nothing in flight
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        drive(1'b1, 4'hC, c[2:0], 1'b0, 1'b0);
        flag_q = fl[k];
        #2;
        exp_both($sformatf("cond%0d_f%0d", c, k), 0, 0, 1, cond_ref(c[2:0], fl[k]), 0);
        chk_all();
      end
    end

    // HLT advances behind an ADD; ADD still writes, later work is frozen
    @(negedge clk); drive(1'b1, 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 4'hF, 3'd0, 1'b0, 1'b0);
    ex_alu_flags = 3'b011; flag_q = 3'b100;
    #2; exp_both("hlt_id", 1, 0, 0, 0, 0); exp_new("hlt_id", 3'b011); chk_all(); chk_new();
    @(negedge clk); drive(1'b1, 4'h0, 3'd0, 1'b0, 1'b0);
    #2; exp_both("halted", 0, 0, 0, 0, 1); chk_all();
    @(negedge clk); drive(1'b1, 4'hC, 3'd7, 1'b0, 1'b0);
    #2; exp_both("halted_add", 0, 0, 0, 0, 1); chk_all();
    @(negedge clk); drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0); rst = 1'b1;
    #2; exp_both("rst_halt", 0, 0, 0, 0, 0); chk_all();
    @(negedge clk); rst = 1'b0; drive(1'b1, 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
    #2; exp_both("rerun", 1, 0, 0, 0, 0); chk_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
